// File: rtl/generation_sequencer.sv
// Computes one Game of Life generation on a 16x16 board with dead (non-wrapping) borders.
// It sweeps one row per cycle from a frozen snapshot into a shadow buffer, then commits it.
module generation_sequencer #(
   parameter int GEN_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  step,
   input  logic [15:0][15:0]     grid_in,
   output logic [15:0][15:0]     grid_next,
   output logic                  busy,
   output logic                  done,
   output logic [GEN_W-1:0]      gen_count,
   output logic                  stable,
   output logic                  extinct,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SWEEP  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [15:0][15:0]  snap_q, snap_d;
   logic [15:0][15:0]  shadow_q, shadow_d;
   logic [15:0][15:0]  grid_q, grid_d;
   logic [3:0]         row_q, row_d;
   logic               done_q, done_d;
   logic [GEN_W-1:0]   gen_q, gen_d;
   logic               stable_q, stable_d;
   logic               extinct_q, extinct_d;

   logic [15:0]        row_above, row_cur, row_below, row_new;
   logic [17:0]        a_pad, m_pad, b_pad;
   logic [3:0]         nbr;

   // Rows outside the board read as all-dead; the 18-bit pads do the same for columns.
   always_comb begin
      row_above = (row_q == 4'd0)  ? 16'd0 : snap_q[row_q - 4'd1];
      row_cur   = snap_q[row_q];
      row_below = (row_q == 4'd15) ? 16'd0 : snap_q[row_q + 4'd1];
      a_pad     = {1'b0, row_above, 1'b0};
      m_pad     = {1'b0, row_cur, 1'b0};
      b_pad     = {1'b0, row_below, 1'b0};
      row_new   = '0;
      nbr       = '0;
      for (int c = 0; c < 16; c++) begin
         nbr = {3'd0, a_pad[c]} + {3'd0, a_pad[c+1]} + {3'd0, a_pad[c+2]}
             + {3'd0, m_pad[c]}                      + {3'd0, m_pad[c+2]}
             + {3'd0, b_pad[c]} + {3'd0, b_pad[c+1]} + {3'd0, b_pad[c+2]};
         row_new[c] = (nbr == 4'd3) || (row_cur[c] && (nbr == 4'd2));
      end
   end

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      shadow_d  = shadow_q;
      grid_d    = grid_q;
      row_d     = row_q;
      done_d    = 1'b0;
      gen_d     = gen_q;
      stable_d  = stable_q;
      extinct_d = extinct_q;
      case (state_q)
         IDLE: begin
            if (step) state_d = LOAD;
         end
         LOAD: begin
            snap_d  = grid_in;
            row_d   = 4'd0;
            state_d = SWEEP;
         end
         SWEEP: begin
            shadow_d[row_q] = row_new;
            if (row_q == 4'd15) state_d = COMMIT;
            else                row_d   = row_q + 4'd1;
         end
         COMMIT: begin
            grid_d    = shadow_q;
            done_d    = 1'b1;
            stable_d  = (shadow_q == snap_q);
            extinct_d = (shadow_q == '0);
            if (gen_q != {GEN_W{1'b1}}) gen_d = gen_q + 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         shadow_q  <= '0;
         grid_q    <= '0;
         row_q     <= '0;
         done_q    <= 1'b0;
         gen_q     <= '0;
         stable_q  <= 1'b0;
         extinct_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         shadow_q  <= shadow_d;
         grid_q    <= grid_d;
         row_q     <= row_d;
         done_q    <= done_d;
         gen_q     <= gen_d;
         stable_q  <= stable_d;
         extinct_q <= extinct_d;
      end
   end

   // done is registered so it coincides with the freshly loaded grid_next.
   assign grid_next = grid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign gen_count = gen_q;
   assign stable    = stable_q;
   assign extinct   = extinct_q;
   assign dbg_state = state_q;

endmodule

// File: doc/generation_sequencer.md
GENERATION_SEQUENCER -- requirements
Module: generation_sequencer

Interface
REQ-001 Parameter GEN_W, default 8; width of the generation counter.
REQ-002 Port clk, input, 1; single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1; reset is synchronous and active-high.
REQ-004 Port step, input, 1; request one Game of Life generation; sampled only in IDLE.
REQ-005 Port grid_in, input, [15:0][15:0]; current board, grid_in[r][c], 1 = live.
REQ-006 Port grid_next, output, [15:0][15:0]; registered next-generation board; same indexing.
REQ-007 Port busy, output, 1; high in every state except IDLE.
REQ-008 Port done, output, 1; one-cycle pulse when grid_next is committed.
REQ-009 Port gen_count, output, GEN_W; generations completed since reset.
REQ-010 Port stable, output, 1; last committed generation equals its source board.
REQ-011 Port extinct, output, 1; last committed generation has zero live cells.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, SWEEP, COMMIT.
REQ-013 In IDLE with step=1, the FSM SHALL go to LOAD; step=0 holds IDLE.
REQ-014 In LOAD, grid_in SHALL be copied into an internal snapshot, the row index SHALL be cleared to 0, and the FSM SHALL go to SWEEP.
REQ-015 Each SWEEP cycle SHALL compute all 16 cells of row r from snapshot rows r-1, r, r+1 and write them into a shadow buffer row r.
REQ-016 Neighbour count SHALL be the sum of the 8 adjacent cells, 4-bit, range 0..8.
REQ-017 Positions outside 0..15 in either axis SHALL count as dead (no wrap-around).
REQ-018 Next cell SHALL be live iff count==3, or the cell is live and count==2.
REQ-019 Row index SHALL increment 0..15; after row 15 the FSM SHALL go to COMMIT; the index SHALL not wrap inside a sweep.
REQ-020 In COMMIT, grid_next SHALL load the shadow buffer, done SHALL pulse high for that one cycle, and the FSM SHALL return to IDLE.
REQ-021 In COMMIT, stable SHALL be set to (shadow == snapshot) and extinct SHALL be set to (shadow == 0).
REQ-022 In COMMIT, gen_count SHALL increment by 1, saturating at 2^GEN_W-1.
REQ-023 Latency: step sampled high at edge N SHALL give done high and the new grid_next during the cycle after edge N+18.
REQ-024 step while busy SHALL be ignored, with no queuing.
REQ-025 Changes on grid_in after LOAD SHALL NOT affect the generation in progress.
REQ-026 grid_next, stable, extinct and gen_count SHALL hold their values between COMMITs.
REQ-027 step held high continuously SHALL produce back-to-back generations, one every 19 cycles, each starting from grid_in re-sampled at LOAD.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE, regardless of current state, including mid-SWEEP.
REQ-029 Reset SHALL clear grid_next, snapshot, shadow, row index and gen_count to 0.
REQ-030 Reset SHALL force busy, done and stable to 0, and extinct to 1.
REQ-031 Reset SHALL take priority over step in the same cycle.
REQ-032 A sweep aborted by reset SHALL produce no done pulse and SHALL leave no partial grid_next update.

Verification
REQ-033 Vertical blinker:
- Stimulus: grid_in live at (7,8),(8,8),(9,8); pulse step.
- Response: done 18 cycles later; grid_next live only at (8,7),(8,8),(8,9); gen_count=1; stable=0; extinct=0.
REQ-034 Block:
- Stimulus: grid_in live at (4,4),(4,5),(5,4),(5,5); step.
- Response: grid_next identical to grid_in; stable=1; extinct=0.
REQ-035 Single cell:
- Stimulus: grid_in live only at (0,0); step.
- Response: grid_next all zero; extinct=1; stable=0.
REQ-036 Edge blinker:
- Stimulus: grid_in live at (0,14),(0,15); step.
- Response: grid_next all zero; no wrap to row 15 or column 0.
REQ-037 Edge blinker, row-0 boundary:
- Stimulus: grid_in live at (0,6),(0,7),(0,8); step.
- Response: grid_next live at (0,7),(1,7) only.
REQ-038 Busy and mid-sweep reset:
- Stimulus: step; re-pulse step at cycle 5; then reset at cycle 10 of a second generation.
- Response: the re-pulse at cycle 5 is ignored, with exactly one done.
- Response: the mid-sweep reset gives no done; gen_count=0; grid_next=0; IDLE on the next cycle.
